// File: rtl/run_controller_if.sv
// Loader handshake and instruction-memory write port shared by loader, controller and memory.
// Latency: none, a bundle of wires.
// Backpressure: loadReady from the controller stalls the loader; imem writes follow accepted words.
interface run_controller_if #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 16
);
    logic                         loadValid;
    logic                         loadReady;
    logic [INSTRUCTION_WIDTH-1:0] loadData;
    logic                         loadLast;
    logic                         imemWe;
    logic [PC_WIDTH-1:0]          imemAddr;
    logic [INSTRUCTION_WIDTH-1:0] imemData;

    // Loader side: offers program words, observes acceptance and the resulting writes.
    modport master (
        output loadValid, loadData, loadLast,
        input  loadReady, imemWe, imemAddr, imemData
    );

    // Controller side: accepts words and drives the memory write port.
    modport slave (
        input  loadValid, loadData, loadLast,
        output loadReady, imemWe, imemAddr, imemData
    );
endinterface

// File: rtl/run_controller.sv
// Loads a program into instruction memory, then runs/halts/single-steps the CPU.
// Latency: words written to memory in the accepting cycle; state changes at the next edge.
// Backpressure: loadReady only in LOAD; a full memory or last word ends loading.
// Optional macro BREAKPOINT_EN adds a PC breakpoint that stops RUN and sets breakHit.
module run_controller #(
    parameter int PC_WIDTH          = 8,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                clock,
    input  logic                isReset,
    run_controller_if.slave     bus,
    input  logic                runCmd,
    input  logic                haltCmd,
    input  logic                stepCmd,
    input  logic                reloadCmd,
    input  logic [PC_WIDTH-1:0] cpuPc,
    input  logic [PC_WIDTH-1:0] breakAddr,
    output logic                cpuReset,
    output logic                cpuEnable,
    output logic [1:0]          state,
    output logic [15:0]         runCycles,
    output logic                breakHit
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] ptr_q, ptr_d;
    logic [15:0]         cycles_q, cycles_d;
    logic                brk_q, brk_d;
    // High on the first RUN cycle after HALT so a resume steps past the breakpoint.
    logic                resume_q, resume_d;

    logic accept;
    logic mem_full;
    logic break_stop;

`ifdef BREAKPOINT_EN
    // Breakpoint stops the CPU in the same cycle the PC matches.
    always_comb begin
        break_stop = (state_q == S_RUN) && !resume_q && (cpuPc == breakAddr);
    end
`else
    logic unused_break;
    // No breakpoint: PC compare inputs are deliberately left unused.
    always_comb begin
        break_stop   = 1'b0;
        unused_break = ^{cpuPc, breakAddr, resume_q};
    end
`endif

    // Output decode: load handshake, memory write port and CPU controls.
    always_comb begin
        accept        = bus.loadValid && (state_q == S_LOAD);
        mem_full      = &ptr_q;
        bus.loadReady = (state_q == S_LOAD);
        bus.imemWe    = accept;
        bus.imemAddr  = ptr_q;
        bus.imemData  = bus.loadData;
        cpuReset      = (state_q == S_LOAD);
        cpuEnable     = ((state_q == S_RUN) || (state_q == S_STEP)) && !break_stop;
        state         = state_q;
        runCycles     = cycles_q;
        breakHit      = brk_q;
    end

    // Next-state logic for the controller FSM, write pointer and cycle counter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cycles_d = cycles_q;
        brk_d    = brk_q;
        resume_d = 1'b0;

        if (cpuEnable && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    // Stop at the top address rather than wrapping onto word 0.
                    if (!mem_full) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (bus.loadLast || mem_full) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (reloadCmd) begin
                    state_d  = S_LOAD;
                    ptr_d    = '0;
                    cycles_d = '0;
                end else if (runCmd) begin
                    state_d  = S_RUN;
                    brk_d    = 1'b0;
                    resume_d = 1'b1;
                end else if (stepCmd) begin
                    state_d = S_STEP;
                    brk_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (break_stop) begin
                    state_d = S_HALT;
                    brk_d   = 1'b1;
                end else if (haltCmd) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State registers with synchronous reset back to an empty LOAD.
    always_ff @(posedge clock) begin
        if (isReset) begin
            state_q  <= S_LOAD;
            ptr_q    <= '0;
            cycles_q <= '0;
            brk_q    <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cycles_q <= cycles_d;
            brk_q    <= brk_d;
            resume_q <= resume_d;
        end
    end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: 8-bit-PC instance for control flow, 2-bit-PC instance for memory-full.
// Latency: expected memory writes queued when a word is driven, compared when imemWe is seen.
// Backpressure: words offered while loadReady is low must produce no write.
module tb_run_controller;

    logic        clock;
    logic        isReset;
    logic        runCmd, haltCmd, stepCmd, reloadCmd;
    logic [7:0]  cpuPc, breakAddr;
    logic        cpuReset, cpuEnable, breakHit;
    logic [1:0]  state;
    logic [15:0] runCycles;

    logic        s_cpuReset, s_cpuEnable, s_breakHit;
    logic [1:0]  s_state;
    logic [15:0] s_runCycles;

    int vectors;
    int miscompares;

    logic [31:0] q8[$];
    logic [31:0] q2[$];

    run_controller_if #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) lb ();
    run_controller_if #(.PC_WIDTH(2), .INSTRUCTION_WIDTH(16)) sb ();

    run_controller #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16)) dut (
        .clock(clock), .isReset(isReset), .bus(lb),
        .runCmd(runCmd), .haltCmd(haltCmd), .stepCmd(stepCmd), .reloadCmd(reloadCmd),
        .cpuPc(cpuPc), .breakAddr(breakAddr),
        .cpuReset(cpuReset), .cpuEnable(cpuEnable), .state(state),
        .runCycles(runCycles), .breakHit(breakHit)
    );

    run_controller #(.PC_WIDTH(2), .INSTRUCTION_WIDTH(16)) dut_small (
        .clock(clock), .isReset(isReset), .bus(sb),
        .runCmd(1'b0), .haltCmd(1'b0), .stepCmd(1'b0), .reloadCmd(1'b0),
        .cpuPc(2'b00), .breakAddr(2'b11),
        .cpuReset(s_cpuReset), .cpuEnable(s_cpuEnable), .state(s_state),
        .runCycles(s_runCycles), .breakHit(s_breakHit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one word into the large instance for a cycle and queue the write it must cause.
    task automatic send8(input logic [15:0] data, input logic last, input logic [7:0] addr);
        lb.loadValid = 1'b1;
        lb.loadData  = data;
        lb.loadLast  = last;
        q8.push_back({8'h00, addr, data});
        @(posedge clock); #1;
        lb.loadValid = 1'b0;
        lb.loadLast  = 1'b0;
    endtask

    // Write monitors: every observed memory write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (lb.imemWe === 1'b1) begin
            if (q8.size() == 0) check_vec("wr8_extra", {24'h0, lb.imemAddr}, 32'hFFFF_FFFF);
            else check_vec("wr8", {8'h00, lb.imemAddr, lb.imemData}, q8.pop_front());
        end
        if (sb.imemWe === 1'b1) begin
            if (q2.size() == 0) check_vec("wr2_extra", {30'h0, sb.imemAddr}, 32'hFFFF_FFFF);
            else check_vec("wr2", {14'h0, sb.imemAddr, sb.imemData}, q2.pop_front());
        end
    end

    initial begin
        vectors = 0; miscompares = 0;
        isReset = 1'b1;
        runCmd = 0; haltCmd = 0; stepCmd = 0; reloadCmd = 0;
        cpuPc = 8'h00; breakAddr = 8'hFF;
        lb.loadValid = 0; lb.loadData = '0; lb.loadLast = 0;
        sb.loadValid = 0; sb.loadData = '0; sb.loadLast = 0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_vec("rst_state",     32'(state), 0);
        check_vec("rst_cpuReset",  32'(cpuReset), 1);
        check_vec("rst_loadReady", 32'(lb.loadReady), 1);
        check_vec("rst_cpuEnable", 32'(cpuEnable), 0);
        check_vec("rst_runCycles", 32'(runCycles), 0);
        check_vec("rst_breakHit",  32'(breakHit), 0);
        check_vec("rst_imemWe",    32'(lb.imemWe), 0);
        isReset = 1'b0;

        // Commands are ignored while loading.
        runCmd = 1; stepCmd = 1;
        @(posedge clock); #1;
        runCmd = 0; stepCmd = 0;
        check_vec("load_cmd_ignored", 32'(state), 0);

        // Three-word program, last word flagged, valid held throughout.
        send8(16'h1111, 1'b0, 8'd0);
        lb.loadValid = 1'b1;
        send8(16'h2222, 1'b0, 8'd1);
        lb.loadValid = 1'b1;
        send8(16'h3333, 1'b1, 8'd2);
        check_vec("load_done_state", 32'(state), 1);
        check_vec("load_done_ready", 32'(lb.loadReady), 0);
        // A further word offered in HALT must not be written.
        lb.loadValid = 1'b1; lb.loadData = 16'h4444;
        @(negedge clock);
        check_vec("halt_stall_we", 32'(lb.imemWe), 0);
        @(posedge clock); #1;
        lb.loadValid = 1'b0;
        check_vec("halt_stall_state", 32'(state), 1);

        // Memory-full on the 2-bit instance: five words offered, four written.
        for (int i = 0; i < 5; i++) begin
            sb.loadValid = 1'b1;
            sb.loadData  = 16'h00A0 + 16'(i);
            sb.loadLast  = 1'b0;
            if (i < 4) q2.push_back({14'h0, 2'(i), 16'h00A0 + 16'(i)});
            @(posedge clock); #1;
            if (i == 3) check_vec("full_halt", 32'(s_state), 1);
        end
        check_vec("full_stall_state", 32'(s_state), 1);
        check_vec("full_stall_ready", 32'(sb.loadReady), 0);
        sb.loadValid = 1'b0;

        // Single step, then a ten-cycle run.
        stepCmd = 1;
        @(posedge clock); #1;
        stepCmd = 0;
        check_vec("step_state",  32'(state), 3);
        check_vec("step_enable", 32'(cpuEnable), 1);
        check_vec("step_cycles0", 32'(runCycles), 0);
        @(posedge clock); #1;
        check_vec("step_back_halt", 32'(state), 1);
        check_vec("step_enable_off", 32'(cpuEnable), 0);
        check_vec("step_cycles1", 32'(runCycles), 1);
        runCmd = 1;
        @(posedge clock); #1;
        runCmd = 0;
        check_vec("run_state", 32'(state), 2);
        check_vec("run_enable", 32'(cpuEnable), 1);
        reloadCmd = 1; stepCmd = 1;
        @(posedge clock); #1;
        reloadCmd = 0; stepCmd = 0;
        check_vec("run_ignore_cmds", 32'(state), 2);
        repeat (8) @(posedge clock);
        #1;
        check_vec("run_cycles10", 32'(runCycles), 10);
        haltCmd = 1;
        @(posedge clock); #1;
        haltCmd = 0;
        check_vec("halt_state", 32'(state), 1);
        check_vec("halt_cycles11", 32'(runCycles), 11);

`ifdef BREAKPOINT_EN
        // Breakpoint at 5 with the PC counting up from 0.
        breakAddr = 8'd5;
        cpuPc = 8'd0;
        runCmd = 1;
        @(posedge clock); #1;
        runCmd = 0;
        for (int k = 0; k < 6; k++) begin
            cpuPc = 8'(k);
            @(negedge clock);
            check_vec($sformatf("bp_enable_pc%0d", k), 32'(cpuEnable), (k == 5) ? 0 : 1);
            @(posedge clock); #1;
        end
        check_vec("bp_state",  32'(state), 1);
        check_vec("bp_hit",    32'(breakHit), 1);
        check_vec("bp_cycles", 32'(runCycles), 16);
        runCmd = 1;
        @(posedge clock); #1;
        runCmd = 0;
        check_vec("bp_resume_hit",    32'(breakHit), 0);
        check_vec("bp_resume_enable", 32'(cpuEnable), 1);
        check_vec("bp_resume_state",  32'(state), 2);
        cpuPc = 8'd6;
        haltCmd = 1;
        @(posedge clock); #1;
        haltCmd = 0;
        check_vec("bp_after_state",  32'(state), 1);
        check_vec("bp_after_cycles", 32'(runCycles), 17);
`else
        // Without the breakpoint feature a matching PC has no effect.
        breakAddr = 8'd5;
        cpuPc = 8'd5;
        runCmd = 1;
        @(posedge clock); #1;
        runCmd = 0;
        repeat (2) begin
            @(negedge clock);
            check_vec("nobp_enable", 32'(cpuEnable), 1);
            check_vec("nobp_hit", 32'(breakHit), 0);
            @(posedge clock); #1;
        end
        haltCmd = 1;
        @(posedge clock); #1;
        haltCmd = 0;
        check_vec("nobp_state",  32'(state), 1);
        check_vec("nobp_cycles", 32'(runCycles), 14);
`endif
        breakAddr = 8'hFF;
        cpuPc = 8'd0;

        // reload beats run when both arrive in HALT.
        reloadCmd = 1; runCmd = 1;
        @(posedge clock); #1;
        reloadCmd = 0; runCmd = 0;
        check_vec("reload_state",  32'(state), 0);
        check_vec("reload_enable", 32'(cpuEnable), 0);
        check_vec("reload_cycles", 32'(runCycles), 0);
        check_vec("reload_ready",  32'(lb.loadReady), 1);
        send8(16'h7777, 1'b1, 8'd0);
        check_vec("reload_load_halt", 32'(state), 1);

        // Reset in RUN at runCycles=7 with haltCmd also asserted.
        runCmd = 1;
        @(posedge clock); #1;
        runCmd = 0;
        repeat (7) @(posedge clock);
        #1;
        check_vec("pre_rst_cycles", 32'(runCycles), 7);
        check_vec("pre_rst_state",  32'(state), 2);
        isReset = 1; haltCmd = 1;
        @(posedge clock); #1;
        isReset = 0; haltCmd = 0;
        check_vec("run_rst_state",    32'(state), 0);
        check_vec("run_rst_cycles",   32'(runCycles), 0);
        check_vec("run_rst_cpuReset", 32'(cpuReset), 1);
        check_vec("run_rst_enable",   32'(cpuEnable), 0);

        // Reset part-way through a load discards progress.
        send8(16'h5555, 1'b0, 8'd0);
        lb.loadValid = 1'b1;
        send8(16'h6666, 1'b0, 8'd1);
        isReset = 1;
        @(posedge clock); #1;
        isReset = 0;
        send8(16'hBEEF, 1'b1, 8'd0);
        check_vec("reload_after_rst_state", 32'(state), 1);

        repeat (2) @(posedge clock);
        #1;
        check_vec("q8_drained", 32'(q8.size()), 0);
        check_vec("q2_drained", 32'(q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
